// File: rtl/kudu_dv_pkg.sv
// Shared types for the kudu data-bus verification monitors.
// Covers memory command info, tracked entries, monitor error codes and saturating helpers.
package kudu_dv_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic        is_cap;
    } mem_cmd_t;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_UNSTABLE = 3'd1,
        ERR_ORDER    = 3'd2,
        ERR_SPUR     = 3'd3,
        ERR_OVF      = 3'd4
    } mon_err_e;

    // Timestamps are stored at full width; monitors truncate to their own LatW.
    localparam int unsigned MonTsW = 32;

    typedef struct packed {
        logic [31:0]       addr;
        logic              we;
        logic              is_cap;
        logic [MonTsW-1:0] ts;
    } mon_entry_t;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/dv_sync_fifo.sv
// Single-clock FIFO of an arbitrary type; Depth must be a power of two.
// A push and a pop in the same cycle are both honoured when the FIFO is full.
module dv_sync_fifo #(
    parameter type         T     = logic,
    parameter int unsigned Depth = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  T                       din,
    output T                       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(Depth):0] count
);
    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned CW = AW + 1;

    T mem [Depth];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(Depth));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/dbus_mem_monitor.sv
// Passive checker on the core <-> data memory bus: request stability, response ordering,
// outstanding tracking, per-request watch flags, latency and traffic statistics.
//
//   state      | meaning
//   S_IDLE     | no request waiting for grant
//   S_WAIT_GNT | request seen without grant; fields latched and must hold until granted
module dbus_mem_monitor
    import kudu_dv_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 4,
    parameter logic [31:0] WatchBase      = 32'h8003_0000,
    parameter logic [31:0] WatchSize      = 32'h0000_1000,
    parameter int unsigned LatW           = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_req,
    input  logic        data_gnt,
    input  logic        data_rvalid,
    input  logic        data_we,
    input  logic [3:0]  data_be,
    input  logic        data_is_cap,
    input  logic [31:0] data_addr,
    input  logic        data_err,
    input  mem_cmd_t    data_resp_info,
    output logic [7:0]  data_flag,
    input  logic        stat_print_req,
    output logic        proto_err_o,
    output logic [2:0]  err_code_o,
    output logic [2:0]  outstanding_o
);
    localparam int unsigned CntW = $clog2(MaxOutstanding) + 1;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_WAIT_GNT = 1'b1
    } req_state_e;

    req_state_e state_q, state_d;
    logic latch_en, unstable, fields_diff;
    logic [31:0] lat_addr;
    logic        lat_we;
    logic [3:0]  lat_be;
    logic        lat_is_cap;

    logic [LatW-1:0] ts_q, lat, lat_max;
    logic [31:0] n_ld, n_st, n_cap, n_err, n_rsp, lat_sum;

    logic accept, fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CntW-1:0] fifo_count;
    mon_entry_t push_entry, head;

    logic err_ovf, err_spur, err_order, err_any;
    mon_err_e err_code_d, err_code_q;
    logic proto_err_q;

    logic [32:0] addr_ext, win_lo, win_hi;
    logic in_window;

    // Window compare is one bit wider so a window ending at 2^32 does not wrap.
    assign addr_ext  = {1'b0, data_addr};
    assign win_lo    = {1'b0, WatchBase};
    assign win_hi    = win_lo + {1'b0, WatchSize};
    assign in_window = (WatchSize != '0) && (addr_ext >= win_lo) && (addr_ext < win_hi);

    always_comb begin
        data_flag = '0;
        if (data_req) begin
            data_flag[0] = in_window;
            data_flag[1] = data_is_cap && (data_addr[2:0] != 3'b000);
        end
    end

    assign fields_diff = (data_addr != lat_addr) || (data_we != lat_we) ||
                         (data_be != lat_be) || (data_is_cap != lat_is_cap);

    always_comb begin
        state_d  = state_q;
        latch_en = 1'b0;
        unstable = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (data_req && !data_gnt) begin
                    state_d  = S_WAIT_GNT;
                    latch_en = 1'b1;
                end
            end
            S_WAIT_GNT: begin
                if (!data_req || fields_diff) begin
                    unstable = 1'b1;
                    state_d  = S_IDLE;
                end else if (data_gnt) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            lat_addr   <= '0;
            lat_we     <= 1'b0;
            lat_be     <= '0;
            lat_is_cap <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch_en) begin
                lat_addr   <= data_addr;
                lat_we     <= data_we;
                lat_be     <= data_be;
                lat_is_cap <= data_is_cap;
            end
        end
    end

    assign accept     = data_req & data_gnt;
    assign fifo_pop   = data_rvalid & ~fifo_empty;
    assign fifo_push  = accept;
    assign push_entry = '{addr: data_addr, we: data_we, is_cap: data_is_cap, ts: MonTsW'(ts_q)};

    dv_sync_fifo #(
        .T     (mon_entry_t),
        .Depth (MaxOutstanding)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (push_entry),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Modular subtraction keeps latency correct across timestamp wrap.
    assign lat = LatW'(MonTsW'(ts_q) - head.ts);

    assign err_ovf   = accept & fifo_full & ~data_rvalid;
    assign err_spur  = data_rvalid & fifo_empty;
    assign err_order = fifo_pop & ({data_resp_info.addr, data_resp_info.we, data_resp_info.is_cap}
                                   != {head.addr, head.we, head.is_cap});
    assign err_any   = err_ovf | err_spur | err_order | unstable;

    always_comb begin
        err_code_d = ERR_NONE;
        if (err_ovf)        err_code_d = ERR_OVF;
        else if (err_spur)  err_code_d = ERR_SPUR;
        else if (err_order) err_code_d = ERR_ORDER;
        else if (unstable)  err_code_d = ERR_UNSTABLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else if (!proto_err_q && err_any) begin
            proto_err_q <= 1'b1;
            err_code_q  <= err_code_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q    <= '0;
            n_ld    <= '0;
            n_st    <= '0;
            n_cap   <= '0;
            n_err   <= '0;
            n_rsp   <= '0;
            lat_sum <= '0;
            lat_max <= '0;
        end else begin
            ts_q <= ts_q + LatW'(1);
            if (accept && !data_we)     n_ld  <= sat_add32(n_ld, 32'd1);
            if (accept && data_we)      n_st  <= sat_add32(n_st, 32'd1);
            if (accept && data_is_cap)  n_cap <= sat_add32(n_cap, 32'd1);
            if (data_rvalid && data_err) n_err <= sat_add32(n_err, 32'd1);
            if (fifo_pop) begin
                n_rsp   <= sat_add32(n_rsp, 32'd1);
                lat_sum <= sat_add32(lat_sum, 32'(lat));
                if (lat > lat_max) lat_max <= lat;
            end
        end
    end

    assign proto_err_o   = proto_err_q;
    assign err_code_o    = err_code_q;
    assign outstanding_o = 3'(fifo_count);

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            if (err_ovf)   $display("%m: protocol error code=%0d (overflow) addr=%08h", ERR_OVF, data_addr);
            if (err_spur)  $display("%m: protocol error code=%0d (spurious rvalid)", ERR_SPUR);
            if (err_order) $display("%m: protocol error code=%0d (order) resp=%08h head=%08h",
                                    ERR_ORDER, data_resp_info.addr, head.addr);
            if (unstable)  $display("%m: protocol error code=%0d (unstable request)", ERR_UNSTABLE);
            if (stat_print_req)
                $display("%m: stats ld=%0d st=%0d cap=%0d err=%0d max_lat=%0d avg_lat=%0d outstanding=%0d",
                         n_ld, n_st, n_cap, n_err, lat_max,
                         (n_rsp != 0) ? lat_sum / n_rsp : 32'd0, fifo_count);
        end
    end
`endif

endmodule

// File: tb/tb_dbus_mem_monitor.sv
// Self-checking bench for dbus_mem_monitor: directed protocol scenarios plus randomized
// legal traffic, all compared against a transaction-level model.
module tb_dbus_mem_monitor;
    import kudu_dv_pkg::*;

    localparam logic [31:0] WBASE = 32'h8003_0000;
    localparam logic [31:0] WSIZE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        data_req = 1'b0, data_gnt = 1'b0, data_rvalid = 1'b0, data_we = 1'b0;
    logic [3:0]  data_be = 4'hF;
    logic        data_is_cap = 1'b0, data_err = 1'b0, stat_print_req = 1'b0;
    logic [31:0] data_addr = '0;
    mem_cmd_t    resp_info = '0;
    logic [7:0]  data_flag;
    logic        proto_err_o;
    logic [2:0]  err_code_o, outstanding_o;

    always #5 clk = ~clk;

    dbus_mem_monitor dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_req       (data_req),
        .data_gnt       (data_gnt),
        .data_rvalid    (data_rvalid),
        .data_we        (data_we),
        .data_be        (data_be),
        .data_is_cap    (data_is_cap),
        .data_addr      (data_addr),
        .data_err       (data_err),
        .data_resp_info (resp_info),
        .data_flag      (data_flag),
        .stat_print_req (stat_print_req),
        .proto_err_o    (proto_err_o),
        .err_code_o     (err_code_o),
        .outstanding_o  (outstanding_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic        is_cap;
        int          ts;
    } ent_t;

    ent_t        mq[$];
    int          m_ts, m_code;
    bit          m_err, m_pend;
    logic [31:0] p_addr;
    logic        p_we, p_cap;
    logic [3:0]  p_be;
    longint      m_ld, m_st, m_cap, m_nerr, m_lat_max, m_lat_sum;
    bit          use_ovr = 1'b0;
    mem_cmd_t    ovr;
    int          n_checks = 0, n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_flag();
        longint a, b, s;
        logic [7:0] f;
        f = '0;
        a = longint'(data_addr);
        b = longint'(WBASE);
        s = longint'(WSIZE);
        if (data_req) begin
            f[0] = (s != 0) && (a >= b) && (a < b + s);
            f[1] = data_is_cap && (a % 8 != 0);
        end
        return f;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ts = 0; m_code = 0; m_err = 0; m_pend = 0;
        m_ld = 0; m_st = 0; m_cap = 0; m_nerr = 0; m_lat_max = 0; m_lat_sum = 0;
    endtask

    // Called just after a falling edge with the inputs for the coming cycle already set.
    task automatic cyc();
        ent_t h;
        bit acc, full0, unst, ord, spur, ovf;
        int code;
        longint lat;
        unst = 0; ord = 0; spur = 0; ovf = 0;
        if (use_ovr) resp_info = ovr;
        else if (mq.size() > 0) resp_info = '{addr: mq[0].addr, we: mq[0].we, is_cap: mq[0].is_cap};
        else resp_info = '0;
        #1;
        check_val("data_flag", data_flag, exp_flag());

        acc   = data_req && data_gnt;
        full0 = (mq.size() == 4);
        if (m_pend) begin
            if (!data_req || data_addr != p_addr || data_we != p_we || data_be != p_be || data_is_cap != p_cap) begin
                unst = 1; m_pend = 0;
            end else if (data_gnt) m_pend = 0;
        end else if (data_req && !data_gnt) begin
            m_pend = 1; p_addr = data_addr; p_we = data_we; p_be = data_be; p_cap = data_is_cap;
        end
        if (data_rvalid) begin
            if (data_err) m_nerr++;
            if (mq.size() == 0) spur = 1;
            else begin
                h = mq.pop_front();
                if (resp_info.addr != h.addr || resp_info.we != h.we || resp_info.is_cap != h.is_cap) ord = 1;
                lat = longint'(m_ts - h.ts) % 65536;
                if (lat > m_lat_max) m_lat_max = lat;
                m_lat_sum += lat;
            end
        end
        if (acc) begin
            if (data_we) m_st++; else m_ld++;
            if (data_is_cap) m_cap++;
            if (full0 && !data_rvalid) ovf = 1;
            else mq.push_back('{addr: data_addr, we: data_we, is_cap: data_is_cap, ts: m_ts});
        end
        code = ovf ? 4 : spur ? 3 : ord ? 2 : unst ? 1 : 0;
        if (!m_err && code != 0) begin m_err = 1; m_code = code; end
        m_ts++;

        @(posedge clk); #1;
        check_val("outstanding", outstanding_o, mq.size());
        check_val("proto_err", proto_err_o, m_err);
        check_val("err_code", err_code_o, m_code);
        @(negedge clk);
    endtask

    task automatic drv(input bit req, input bit gnt, input bit rv, input bit we, input bit cap,
                       input logic [31:0] addr);
        data_req = req; data_gnt = gnt; data_rvalid = rv; data_we = we;
        data_is_cap = cap; data_addr = addr; data_be = 4'hF; data_err = 1'b0;
        cyc();
    endtask

    task automatic do_reset();
        data_req = 0; data_gnt = 0; data_rvalid = 0; data_we = 0; data_is_cap = 0;
        data_addr = '0; data_err = 0; stat_print_req = 0; use_ovr = 0;
        rst_n = 1'b0;
        model_reset();
        #2;
        check_val("rst_outstanding", outstanding_o, 0);
        check_val("rst_proto_err", proto_err_o, 0);
        check_val("rst_err_code", err_code_o, ERR_NONE);
        check_val("rst_n_ld", dut.n_ld, 0);
        check_val("rst_n_st", dut.n_st, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_stats();
        check_val("n_ld", dut.n_ld, m_ld);
        check_val("n_st", dut.n_st, m_st);
        check_val("n_cap", dut.n_cap, m_cap);
        check_val("n_err", dut.n_err, m_nerr);
        check_val("lat_max", dut.lat_max, m_lat_max);
        check_val("lat_sum", dut.lat_sum, m_lat_sum);
    endtask

    initial begin
        bit rv, req, gnt;
        @(negedge clk);
        do_reset();

        // back-to-back loads, immediate grant, one-cycle response
        drv(1, 1, 0, 0, 0, 32'h8000_0000);
        drv(1, 1, 1, 0, 0, 32'h8000_0004);
        drv(0, 0, 1, 0, 0, 32'h0);
        drv(0, 0, 0, 0, 0, 32'h0);
        check_val("b2b_n_ld", dut.n_ld, 2);
        check_val("b2b_max_lat", dut.lat_max, 1);
        check_val("b2b_no_err", proto_err_o, 0);
        check_stats();

        // address changes while waiting for grant
        do_reset();
        drv(1, 0, 0, 0, 0, 32'h8000_0010);
        drv(1, 0, 0, 0, 0, 32'h8000_0014);
        drv(1, 0, 0, 0, 0, 32'h8000_0014);
        drv(1, 1, 0, 0, 0, 32'h8000_0014);
        check_val("unstable_code", err_code_o, ERR_UNSTABLE);

        // overflow on fifth unanswered accept
        do_reset();
        for (int i = 0; i < 5; i++) drv(1, 1, 0, i[0], 0, 32'h8000_0100 + 32'(i * 4));
        check_val("ovf_code", err_code_o, ERR_OVF);
        check_val("ovf_outstanding", outstanding_o, 4);

        // fifth accept with a simultaneous response is legal when full
        do_reset();
        for (int i = 0; i < 4; i++) drv(1, 1, 0, 0, 1, 32'h8000_0200 + 32'(i * 4));
        drv(1, 1, 1, 1, 0, 32'h8000_0210);
        check_val("full_pushpop_err", proto_err_o, 0);
        check_val("full_pushpop_outst", outstanding_o, 4);
        check_stats();

        // spurious response after reset
        do_reset();
        drv(0, 0, 1, 0, 0, 32'h0);
        check_val("spur_code", err_code_o, ERR_SPUR);

        // response info does not match the head entry
        do_reset();
        drv(1, 1, 0, 0, 0, 32'h8000_0004);
        use_ovr = 1; ovr = '{addr: 32'h8000_0008, we: 1'b0, is_cap: 1'b0};
        drv(0, 0, 1, 0, 0, 32'h0);
        use_ovr = 0;
        check_val("order_code", err_code_o, ERR_ORDER);

        // watch window and capability alignment flags
        do_reset();
        data_req = 1; data_is_cap = 1; data_addr = 32'h8003_0004; #1;
        check_val("flag_cap_win", data_flag, 8'h03);
        data_addr = 32'h8003_1000; #1;
        check_val("flag_win_end", data_flag, 8'h00);
        data_addr = 32'h8002_FFFF; data_is_cap = 0; #1;
        check_val("flag_below_win", data_flag, 8'h00);
        data_addr = 32'h8003_0FFF; #1;
        check_val("flag_win_last", data_flag, 8'h01);
        data_req = 0; data_is_cap = 1; data_addr = 32'h8003_0004; #1;
        check_val("flag_noreq", data_flag, 8'h00);
        @(negedge clk);
        drv(1, 1, 0, 0, 1, 32'h8003_0004);
        drv(0, 0, 1, 0, 0, 32'h0);

        // reset with requests outstanding
        do_reset();
        for (int i = 0; i < 3; i++) drv(1, 1, 0, 0, 0, 32'h8000_0300 + 32'(i * 4));
        check_val("pre_rst_outst", outstanding_o, 3);
        do_reset();
        drv(0, 0, 0, 0, 0, 32'h0);
        check_val("post_rst_err", proto_err_o, 0);
        check_val("post_rst_n_ld", dut.n_ld, 0);

        // randomized legal traffic
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            rv = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
            if (m_pend) begin
                req = 1;
            end else begin
                req = ($urandom_range(0, 3) != 0);
                data_addr = ($urandom_range(0, 1) == 1) ? (WBASE - 32'h800 + ($urandom & 32'h1FFF)) : $urandom;
                data_we = $urandom_range(0, 1) == 1;
                data_is_cap = $urandom_range(0, 1) == 1;
                data_be = 4'($urandom);
            end
            gnt = ($urandom_range(0, 1) == 1);
            if (mq.size() == 4 && !rv) gnt = 0;
            data_req = req; data_gnt = req ? gnt : 1'b0; data_rvalid = rv;
            data_err = rv && ($urandom_range(0, 7) == 0);
            stat_print_req = (n == 700);
            cyc();
        end
        stat_print_req = 0;
        for (int n = 0; n < 8 && mq.size() > 0; n++) drv(0, 0, 1, 0, 0, 32'h0);
        check_val("rand_drained", outstanding_o, 0);
        check_stats();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
